// File: rtl/axi_lite_master_if_if.sv
// AXI4-Lite five-channel bus bundle shared by the master and the slave it talks to.
// The master modport drives addresses, data, valids and response readies.
interface axi_lite_master_if_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axi_lite_master_if.sv
// AXI4-Lite master: converts one write/read command into one bus transaction and returns
// the captured response on a valid/ready port. A sticky watchdog flags slow slaves.
module axi_lite_master_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_write,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    timeout,
    axi_lite_master_if_if.master    axi
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {IDLE, WR, WR_B, RD_AR, RD_R, RSP} state_t;

    state_t           state;
    logic             aw_done;
    logic             w_done;
    logic [CNT_W-1:0] wd_cnt;
    logic             aw_hs;
    logic             w_hs;
    logic             busy;

    assign cmd_ready = (state == IDLE);
    assign aw_hs     = axi.awvalid && axi.awready;
    assign w_hs      = axi.wvalid && axi.wready;
    assign busy      = (state == WR) || (state == WR_B) || (state == RD_AR) || (state == RD_R);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            wd_cnt      <= '0;
            timeout     <= 1'b0;
            axi.awaddr  <= '0;
            axi.awvalid <= 1'b0;
            axi.wdata   <= '0;
            axi.wstrb   <= '0;
            axi.wvalid  <= 1'b0;
            axi.bready  <= 1'b0;
            axi.araddr  <= '0;
            axi.arvalid <= 1'b0;
            axi.rready  <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_write   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_resp    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        wd_cnt  <= '0;
                        timeout <= 1'b0;
                        if (cmd_write) begin
                            axi.awaddr  <= cmd_addr;
                            axi.wdata   <= cmd_wdata;
                            axi.wstrb   <= cmd_wstrb;
                            axi.awvalid <= 1'b1;
                            axi.wvalid  <= 1'b1;
                            aw_done     <= 1'b0;
                            w_done      <= 1'b0;
                            state       <= WR;
                        end else begin
                            axi.araddr  <= cmd_addr;
                            axi.arvalid <= 1'b1;
                            state       <= RD_AR;
                        end
                    end
                end
                // AW and W complete independently; B is only awaited once both have gone
                WR: begin
                    if (aw_hs) begin
                        axi.awvalid <= 1'b0;
                        aw_done     <= 1'b1;
                    end
                    if (w_hs) begin
                        axi.wvalid <= 1'b0;
                        w_done     <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        axi.bready <= 1'b1;
                        state      <= WR_B;
                    end
                end
                WR_B: begin
                    if (axi.bvalid) begin
                        axi.bready <= 1'b0;
                        rsp_write  <= 1'b1;
                        rsp_rdata  <= '0;
                        rsp_resp   <= axi.bresp;
                        rsp_valid  <= 1'b1;
                        state      <= RSP;
                    end
                end
                RD_AR: begin
                    if (axi.arready) begin
                        axi.arvalid <= 1'b0;
                        axi.rready  <= 1'b1;
                        state       <= RD_R;
                    end
                end
                RD_R: begin
                    if (axi.rvalid) begin
                        axi.rready <= 1'b0;
                        rsp_write  <= 1'b0;
                        rsp_rdata  <= axi.rdata;
                        rsp_resp   <= axi.rresp;
                        rsp_valid  <= 1'b1;
                        state      <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Watchdog only reports; the transaction keeps waiting for the slave
            if (TIMEOUT_CYCLES != 0 && busy) begin
                if (wd_cnt != WD_LIMIT) begin
                    wd_cnt <= wd_cnt + 1'b1;
                end
                if (wd_cnt == WD_LIMIT - 1'b1) begin
                    timeout <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_axi_lite_master_if.sv
// Directed bench for axi_lite_master_if with a configurable-latency AXI-Lite slave model
// and a queue of expected responses.
`timescale 1ns/1ps
module tb_axi_lite_master_if;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [3:0]    cmd_wstrb;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic          timeout;

    axi_lite_master_if_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi_lite_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .timeout(timeout),
        .axi(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        w;
        logic [31:0] d;
        logic [1:0]  r;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Slave model configuration and state
    int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    bit          ar_block = 1'b0;
    bit          rd_force = 1'b0;
    logic [1:0]  cfg_bresp = 2'b00;
    logic [1:0]  cfg_rresp = 2'b00;
    logic [31:0] cfg_rdata = 32'h0;
    logic [31:0] mem [16];
    int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    bit          aw_got, w_got, ar_got;
    logic [31:0] s_awaddr, s_wdata, s_araddr;
    logic [3:0]  s_wstrb;
    logic        p_awv, p_wv, p_br, p_arv, p_rr;

    // Slave acts on the falling edge; a handshake at the preceding rising edge is
    // valid-at-previous-negedge together with our ready
    always @(negedge clk) begin
        if (!rst_n) begin
            bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = 2'b00;
            bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = 32'h0; bus.rresp = 2'b00;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            aw_got = 1'b0; w_got = 1'b0; ar_got = 1'b0;
            s_awaddr = 32'h0; s_wdata = 32'h0; s_wstrb = 4'h0; s_araddr = 32'h0;
            for (int i = 0; i < 16; i++) mem[i] = 32'h0;
            p_awv = 1'b0; p_wv = 1'b0; p_br = 1'b0; p_arv = 1'b0; p_rr = 1'b0;
        end else begin
            if (bus.awready && p_awv) begin
                bus.awready = 1'b0; aw_got = 1'b1; aw_cnt = 0;
            end else if (bus.awvalid && !bus.awready && !aw_got) begin
                if (aw_cnt >= aw_delay) begin bus.awready = 1'b1; s_awaddr = bus.awaddr; end
                else aw_cnt++;
            end
            if (bus.wready && p_wv) begin
                bus.wready = 1'b0; w_got = 1'b1; w_cnt = 0;
            end else if (bus.wvalid && !bus.wready && !w_got) begin
                if (w_cnt >= w_delay) begin
                    bus.wready = 1'b1; s_wdata = bus.wdata; s_wstrb = bus.wstrb;
                end else w_cnt++;
            end
            if (bus.bvalid && p_br) begin
                bus.bvalid = 1'b0; aw_got = 1'b0; w_got = 1'b0; b_cnt = 0;
            end else if (!bus.bvalid && aw_got && w_got) begin
                if (b_cnt >= b_delay) begin
                    bus.bvalid = 1'b1; bus.bresp = cfg_bresp;
                    for (int b = 0; b < 4; b++)
                        if (s_wstrb[b]) mem[s_awaddr[5:2]][8*b +: 8] = s_wdata[8*b +: 8];
                end else b_cnt++;
            end
            if (bus.arready && p_arv) begin
                bus.arready = 1'b0; ar_got = 1'b1; ar_cnt = 0;
            end else if (bus.arvalid && !bus.arready && !ar_got && !ar_block) begin
                if (ar_cnt >= ar_delay) begin bus.arready = 1'b1; s_araddr = bus.araddr; end
                else ar_cnt++;
            end
            if (bus.rvalid && p_rr) begin
                bus.rvalid = 1'b0; ar_got = 1'b0; r_cnt = 0;
            end else if (ar_got && !bus.rvalid) begin
                if (r_cnt >= r_delay) begin
                    bus.rvalid = 1'b1;
                    bus.rdata  = rd_force ? cfg_rdata : mem[s_araddr[5:2]];
                    bus.rresp  = cfg_rresp;
                end else r_cnt++;
            end
            p_awv = bus.awvalid; p_wv = bus.wvalid; p_br = bus.bready;
            p_arv = bus.arvalid; p_rr = bus.rready;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns one cycle after the accepting edge
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        int g = 0;
        cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
        while (!cmd_ready && g < 50) begin step(1); g++; end
        if (!cmd_ready) check("cmd_accept", 64'(cmd_ready), 64'd1);
        step(1);
        cmd_valid = 1'b0;
    endtask

    task automatic push_exp(input logic w, input logic [31:0] d, input logic [1:0] r);
        rsp_t e;
        e.w = w; e.d = d; e.r = r;
        exp_q.push_back(e);
    endtask

    task automatic wait_valid(input int max);
        int g = 0;
        while (!rsp_valid && g < max) begin step(1); g++; end
    endtask

    task automatic pop_cmp(input string tag);
        rsp_t e;
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_nonempty"}, 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_rsp_write"}, 64'(rsp_write), 64'(e.w));
            check({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'(e.d));
            check({tag, "_rsp_resp"},  64'(rsp_resp),  64'(e.r));
        end
    endtask

    task automatic wait_rsp(input string tag, input int max);
        wait_valid(max);
        pop_cmp(tag);
        rsp_ready = 1'b1;
        step(1);
        rsp_ready = 1'b0;
        check({tag, "_rsp_done"}, 64'(rsp_valid), 64'd0);
        check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
        step(3);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_awvalid", 64'(bus.awvalid), 64'd0);
        check("rst_wvalid", 64'(bus.wvalid), 64'd0);
        check("rst_arvalid", 64'(bus.arvalid), 64'd0);
        check("rst_bready", 64'(bus.bready), 64'd0);
        check("rst_rready", 64'(bus.rready), 64'd0);
        check("rst_awaddr", 64'(bus.awaddr), 64'd0);
        check("rst_wdata", 64'(bus.wdata), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("rst_timeout", 64'(timeout), 64'd0);
        rst_n = 1'b1;
        step(2);

        // 1: zero-wait write, exact latency
        issue(1'b1, 32'h04, 32'hA5, 4'hF);
        push_exp(1'b1, 32'h0, 2'b00);
        check("t1_awvalid", 64'(bus.awvalid), 64'd1);
        check("t1_wvalid", 64'(bus.wvalid), 64'd1);
        check("t1_awaddr", 64'(bus.awaddr), 64'h04);
        check("t1_wdata", 64'(bus.wdata), 64'hA5);
        check("t1_wstrb", 64'(bus.wstrb), 64'hF);
        check("t1_cmd_busy", 64'(cmd_ready), 64'd0);
        step(1);
        check("t1_aw_drop", 64'(bus.awvalid), 64'd0);
        check("t1_w_drop", 64'(bus.wvalid), 64'd0);
        check("t1_bready", 64'(bus.bready), 64'd1);
        check("t1_rsp_early", 64'(rsp_valid), 64'd0);
        step(1);
        pop_cmp("t1");
        rsp_ready = 1'b1;
        step(1);
        rsp_ready = 1'b0;
        check("t1_rsp_done", 64'(rsp_valid), 64'd0);
        check("t1_cmd_ready", 64'(cmd_ready), 64'd1);

        // 2: AW immediate, W three cycles late, non-OKAY bresp
        w_delay = 3; cfg_bresp = 2'b11;
        issue(1'b1, 32'h0C, 32'hA5, 4'hF);
        push_exp(1'b1, 32'h0, 2'b11);
        check("t2_aw_t1", 64'(bus.awvalid), 64'd1);
        step(1);
        check("t2_aw_drop", 64'(bus.awvalid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            check("t2_w_held", 64'(bus.wvalid), 64'd1);
            check("t2_wdata_stable", 64'(bus.wdata), 64'hA5);
            check("t2_no_bready", 64'(bus.bready), 64'd0);
            step(1);
        end
        check("t2_w_drop", 64'(bus.wvalid), 64'd0);
        check("t2_bready", 64'(bus.bready), 64'd1);
        wait_rsp("t2", 20);
        check("t2_single_rsp", 64'(rsp_valid), 64'd0);
        w_delay = 0; cfg_bresp = 2'b00;

        // 3: read with two wait cycles and SLVERR
        r_delay = 2; rd_force = 1'b1; cfg_rdata = 32'h1234_5678; cfg_rresp = 2'b10;
        issue(1'b0, 32'h08, 32'h0, 4'h0);
        push_exp(1'b0, 32'h1234_5678, 2'b10);
        check("t3_arvalid", 64'(bus.arvalid), 64'd1);
        check("t3_araddr", 64'(bus.araddr), 64'h08);
        check("t3_rready_early", 64'(bus.rready), 64'd0);
        step(1);
        check("t3_ar_drop", 64'(bus.arvalid), 64'd0);
        check("t3_rready", 64'(bus.rready), 64'd1);
        wait_rsp("t3", 20);
        r_delay = 0; rd_force = 1'b0; cfg_rresp = 2'b00;

        // 4: response back-pressure, then loopback read of the written word
        issue(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        push_exp(1'b1, 32'h0, 2'b00);
        wait_valid(20);
        pop_cmp("t4w");
        cmd_write = 1'b0; cmd_addr = 32'h10; cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("t4_hold_valid", 64'(rsp_valid), 64'd1);
            check("t4_hold_write", 64'(rsp_write), 64'd1);
            check("t4_hold_rdata", 64'(rsp_rdata), 64'd0);
            check("t4_hold_resp", 64'(rsp_resp), 64'd0);
            check("t4_hold_cmd_ready", 64'(cmd_ready), 64'd0);
            check("t4_no_ar", 64'(bus.arvalid), 64'd0);
        end
        rsp_ready = 1'b1;
        step(1);
        rsp_ready = 1'b0;
        check("t4_released", 64'(rsp_valid), 64'd0);
        check("t4_cmd_ready", 64'(cmd_ready), 64'd1);
        check("t4_not_yet_ar", 64'(bus.arvalid), 64'd0);
        push_exp(1'b0, 32'hDEAD_BEEF, 2'b00);
        step(1);
        cmd_valid = 1'b0;
        check("t4_ar_after", 64'(bus.arvalid), 64'd1);
        check("t4_araddr", 64'(bus.araddr), 64'h10);
        wait_rsp("t4r", 20);

        // 5: watchdog with a stalled read address channel
        ar_block = 1'b1;
        issue(1'b0, 32'h14, 32'h0, 4'h0);
        push_exp(1'b0, 32'h0, 2'b00);
        step(15);
        check("t5_timeout_15", 64'(timeout), 64'd0);
        check("t5_arvalid_15", 64'(bus.arvalid), 64'd1);
        step(1);
        check("t5_timeout_16", 64'(timeout), 64'd1);
        step(3);
        check("t5_timeout_sticky", 64'(timeout), 64'd1);
        check("t5_arvalid_held", 64'(bus.arvalid), 64'd1);
        check("t5_araddr_held", 64'(bus.araddr), 64'h14);
        ar_block = 1'b0;
        wait_rsp("t5", 20);
        check("t5_timeout_after_rsp", 64'(timeout), 64'd1);
        issue(1'b1, 32'h14, 32'h5A, 4'h1);
        push_exp(1'b1, 32'h0, 2'b00);
        check("t5_timeout_cleared", 64'(timeout), 64'd0);
        wait_rsp("t5w", 20);

        // 6: reset while W is pending
        w_delay = 10;
        issue(1'b1, 32'h18, 32'h77, 4'hF);
        step(1);
        check("t6_wvalid_pre", 64'(bus.wvalid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_awvalid", 64'(bus.awvalid), 64'd0);
        check("t6_wvalid", 64'(bus.wvalid), 64'd0);
        check("t6_bready", 64'(bus.bready), 64'd0);
        check("t6_wdata", 64'(bus.wdata), 64'd0);
        check("t6_rsp_valid", 64'(rsp_valid), 64'd0);
        check("t6_cmd_ready", 64'(cmd_ready), 64'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        w_delay = 0;
        step(4);
        check("t6_no_rsp", 64'(rsp_valid), 64'd0);
        check("t6_idle_aw", 64'(bus.awvalid), 64'd0);

        // Loopback with partial strobes: bytes 0 and 2 land, bytes 1 and 3 stay zero
        issue(1'b1, 32'h20, 32'h1122_3344, 4'h5);
        push_exp(1'b1, 32'h0, 2'b00);
        wait_rsp("lb_w", 20);
        issue(1'b0, 32'h20, 32'h0, 4'h0);
        push_exp(1'b0, 32'h0022_0044, 2'b00);
        wait_rsp("lb_r", 20);

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
